// File: rtl/peribus_pkg.sv
// Shared Peribus definitions: bus width, interrupt-controller register map,
// FSM state encoding and STATUS field layout.
package peribus_pkg;

    localparam int unsigned PERIBUS_DATA_W = 16;

    localparam logic [1:0] IRQC_ADDR_PENDING = 2'd0;
    localparam logic [1:0] IRQC_ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] IRQC_ADDR_CONTROL = 2'd2;
    localparam logic [1:0] IRQC_ADDR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } irqc_state_t;

    localparam int unsigned IRQC_STATUS_ID_LSB    = 0;
    localparam int unsigned IRQC_STATUS_INSVC_BIT = 4;
    localparam int unsigned IRQC_STATUS_STATE_LSB = 8;

endpackage

// File: rtl/peribus_irq_ctrl_if.sv
// Peribus register-access port: the core side is master, peripherals are slaves.
interface peribus_irq_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic [1:0]        addr;
    logic [DATA_W-1:0] write_data;
    logic              write_en;
    logic              read_en;
    logic              chipselect;
    logic [DATA_W-1:0] read_data;

    modport master (
        output addr, write_data, write_en, read_en, chipselect,
        input  read_data
    );

    modport slave (
        input  addr, write_data, write_en, read_en, chipselect,
        output read_data
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; combinational.
module irq_prio_enc #(
    parameter int unsigned N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [3:0]       id
);

    always_comb begin
        valid = |req;
        id    = 4'd0;
        // Walk from the top so the lowest set index is the last assignment.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = 4'(i);
            end
        end
    end

endmodule

// File: rtl/peribus_irq_ctrl.sv
// Peribus interrupt controller: edge capture of source lines, register file,
// request/ack/EOI handshake FSM and registered read-back.
module peribus_irq_ctrl
    import peribus_pkg::*;
#(
    parameter int unsigned N_SRC  = 8,
    parameter int unsigned DATA_W = PERIBUS_DATA_W
) (
    input  logic               clock,
    input  logic               reset_n,
    peribus_irq_ctrl_if.slave  bus,
    input  logic [N_SRC-1:0]   src_irq,
    output logic               irq,
    output logic [3:0]         irq_id,
    input  logic               irq_ack
);

    localparam logic [1:0] ST_IDLE    = StIdle;
    localparam logic [1:0] ST_REQ     = StReq;
    localparam logic [1:0] ST_SERVICE = StService;

    logic [N_SRC-1:0]  src_q;
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [N_SRC-1:0]  enable_q, enable_d;
    logic              gie_q, gie_d;
    logic [1:0]        state_q, state_d;
    logic [3:0]        active_id_q, active_id_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;

    logic              cand_valid;
    logic [3:0]        cand_id;
    logic              bus_wr, bus_rd, eoi, ack_take, in_service;
    logic [N_SRC-1:0]  rise, ack_mask;
    logic [15:0]       status;

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .req   (pending_q & enable_q),
        .valid (cand_valid),
        .id    (cand_id)
    );

    assign bus_wr     = bus.chipselect && bus.write_en;
    assign bus_rd     = bus.chipselect && bus.read_en;
    assign in_service = (state_q == ST_SERVICE);
    assign eoi        = bus_wr && (bus.addr == IRQC_ADDR_STATUS) && bus.write_data[0] && in_service;
    assign ack_take   = (state_q == ST_REQ) && gie_q && cand_valid && irq_ack;
    assign rise       = src_irq & ~src_q;
    assign ack_mask   = N_SRC'(1) << cand_id;

    always_comb begin
        pending_d = pending_q;
        if (bus_wr && (bus.addr == IRQC_ADDR_PENDING)) begin
            pending_d = pending_d & ~bus.write_data[N_SRC-1:0];
        end
        if (ack_take) begin
            pending_d = pending_d & ~ack_mask;
        end
        // A fresh edge always wins over a same-cycle clear.
        pending_d = pending_d | rise;

        enable_d = enable_q;
        if (bus_wr && (bus.addr == IRQC_ADDR_ENABLE)) begin
            enable_d = bus.write_data[N_SRC-1:0];
        end

        gie_d = gie_q;
        if (bus_wr && (bus.addr == IRQC_ADDR_CONTROL)) begin
            gie_d = bus.write_data[0];
        end

        active_id_d = ack_take ? cand_id : active_id_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gie_q && cand_valid) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!gie_q || !cand_valid) state_d = ST_IDLE;
                else if (irq_ack)          state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (eoi) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        status = 16'h0000;
        status[IRQC_STATUS_STATE_LSB +: 2] = state_q;
        status[IRQC_STATUS_INSVC_BIT]      = in_service;
        status[IRQC_STATUS_ID_LSB +: 4]    = active_id_q;

        read_data_d = read_data_q;
        if (bus_rd) begin
            read_data_d = '0;
            case (bus.addr)
                IRQC_ADDR_PENDING: read_data_d[N_SRC-1:0] = pending_q;
                IRQC_ADDR_ENABLE:  read_data_d[N_SRC-1:0] = enable_q;
                IRQC_ADDR_CONTROL: read_data_d[0]         = gie_q;
                default:           read_data_d[15:0]      = status;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            src_q       <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            gie_q       <= 1'b0;
            state_q     <= ST_IDLE;
            active_id_q <= 4'd0;
            read_data_q <= '0;
        end else begin
            src_q       <= src_irq;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            gie_q       <= gie_d;
            state_q     <= state_d;
            active_id_q <= active_id_d;
            read_data_q <= read_data_d;
        end
    end

    // irq decodes straight from the state flop, so it cannot glitch.
    assign irq           = (state_q == ST_REQ);
    assign irq_id        = (state_q == ST_REQ)     ? cand_id :
                           (state_q == ST_SERVICE) ? active_id_q : 4'd0;
    assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_peribus_irq_ctrl.sv
// Directed self-checking bench for peribus_irq_ctrl.
module tb_peribus_irq_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] src_irq;
    logic       irq;
    logic [3:0] irq_id;
    logic       irq_ack;
    logic [15:0] rd;

    int checks = 0;
    int errors = 0;

    peribus_irq_ctrl_if #(.DATA_W(16)) pbus ();

    peribus_irq_ctrl #(
        .N_SRC  (8),
        .DATA_W (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (pbus.slave),
        .src_irq (src_irq),
        .irq     (irq),
        .irq_id  (irq_id),
        .irq_ack (irq_ack)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        pbus.chipselect = 1'b1;
        pbus.write_en   = 1'b1;
        pbus.addr       = a;
        pbus.write_data = d;
        cycle();
        pbus.chipselect = 1'b0;
        pbus.write_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        pbus.chipselect = 1'b1;
        pbus.read_en    = 1'b1;
        pbus.addr       = a;
        cycle();
        d = pbus.read_data;
        pbus.chipselect = 1'b0;
        pbus.read_en    = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
    endtask

    initial begin
        reset_n         = 1'b0;
        src_irq         = 8'h00;
        irq_ack         = 1'b0;
        pbus.addr       = 2'd0;
        pbus.write_data = 16'h0000;
        pbus.write_en   = 1'b0;
        pbus.read_en    = 1'b0;
        pbus.chipselect = 1'b0;
        repeat (3) cycle();
        chk("reset_irq", {15'h0, irq}, 16'h0000);
        chk("reset_irq_id", {12'h0, irq_id}, 16'h0000);
        chk("reset_read_data", pbus.read_data, 16'h0000);
        reset_n = 1'b1;
        cycle();

        // 1: reset while a request is outstanding
        bus_write(2'd1, 16'h0001);
        bus_write(2'd2, 16'h0001);
        src_irq = 8'h01;
        cycle();
        cycle();
        chk("t1_irq_before_reset", {15'h0, irq}, 16'h0001);
        reset_n = 1'b0;
        #1;
        chk("t1_irq_async_reset", {15'h0, irq}, 16'h0000);
        src_irq = 8'h00;
        cycle();
        reset_n = 1'b1;
        cycle();
        bus_read(2'd0, rd); chk("t1_pending", rd, 16'h0000);
        bus_read(2'd1, rd); chk("t1_enable", rd, 16'h0000);
        bus_read(2'd2, rd); chk("t1_control", rd, 16'h0000);
        bus_read(2'd3, rd); chk("t1_status", rd, 16'h0000);

        // 2: basic handshake with latency check
        bus_write(2'd1, 16'h0004);
        bus_write(2'd2, 16'h0001);
        bus_read(2'd2, rd); chk("t2_control_rb", rd, 16'h0001);
        src_irq = 8'h04;
        cycle();
        chk("t2_irq_after_1", {15'h0, irq}, 16'h0000);
        cycle();
        chk("t2_irq_after_2", {15'h0, irq}, 16'h0001);
        chk("t2_irq_id", {12'h0, irq_id}, 16'h0002);
        ack();
        chk("t2_irq_after_ack", {15'h0, irq}, 16'h0000);
        chk("t2_irq_id_svc", {12'h0, irq_id}, 16'h0002);
        bus_read(2'd3, rd); chk("t2_status_svc", rd, 16'h0212);
        bus_read(2'd0, rd); chk("t2_pending", rd, 16'h0000);
        bus_write(2'd3, 16'h0001);
        bus_read(2'd3, rd); chk("t2_status_eoi", rd, 16'h0002);
        src_irq = 8'h00;
        cycle();

        // 3: priority, then re-raise after EOI
        bus_write(2'd1, 16'h00FF);
        src_irq = 8'h22;
        cycle();
        cycle();
        chk("t3_irq", {15'h0, irq}, 16'h0001);
        chk("t3_irq_id_first", {12'h0, irq_id}, 16'h0001);
        ack();
        bus_write(2'd3, 16'h0001);
        chk("t3_irq_low_after_eoi", {15'h0, irq}, 16'h0000);
        cycle();
        chk("t3_irq_reraise", {15'h0, irq}, 16'h0001);
        chk("t3_irq_id_second", {12'h0, irq_id}, 16'h0005);
        ack();
        bus_write(2'd3, 16'h0001);
        src_irq = 8'h00;
        cycle();

        // 4: masked source stays pending, unmasking raises irq
        bus_write(2'd1, 16'h0000);
        src_irq = 8'h08;
        cycle();
        cycle();
        bus_read(2'd0, rd); chk("t4_pending", rd, 16'h0008);
        chk("t4_irq_masked", {15'h0, irq}, 16'h0000);
        bus_write(2'd1, 16'h0008);
        cycle();
        chk("t4_irq_unmasked", {15'h0, irq}, 16'h0001);
        chk("t4_irq_id", {12'h0, irq_id}, 16'h0003);
        ack();
        bus_write(2'd3, 16'h0001);
        src_irq = 8'h00;
        cycle();

        // 5: W1C withdraws a request; a later ack is ignored
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        cycle();
        bus_write(2'd1, 16'h0010);
        bus_write(2'd2, 16'h0001);
        src_irq = 8'h10;
        cycle();
        cycle();
        chk("t5_irq", {15'h0, irq}, 16'h0001);
        chk("t5_irq_id", {12'h0, irq_id}, 16'h0004);
        bus_write(2'd0, 16'h0010);
        cycle();
        chk("t5_irq_withdrawn", {15'h0, irq}, 16'h0000);
        ack();
        chk("t5_irq_after_stray_ack", {15'h0, irq}, 16'h0000);
        bus_read(2'd3, rd); chk("t5_status", rd, 16'h0000);
        src_irq = 8'h00;
        cycle();

        // 6: set beats same-cycle W1C; held level sets only once
        src_irq = 8'h01;
        bus_write(2'd0, 16'h0001);
        repeat (9) cycle();
        bus_read(2'd0, rd); chk("t6_pending_set", rd, 16'h0001);
        bus_write(2'd0, 16'h0001);
        cycle();
        bus_read(2'd0, rd); chk("t6_pending_once", rd, 16'h0000);
        bus_write(2'd3, 16'h0001);
        bus_read(2'd3, rd); chk("t6_eoi_ignored", rd, 16'h0000);
        chk("t6_irq", {15'h0, irq}, 16'h0000);
        src_irq = 8'h00;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
